// File: rtl/core_bus_arbiter.sv
// Shares one memory port between instruction fetch and data access; optional ARBITER_ROUND_ROBIN_EN fairness.
// Latency: grant registered one cycle after the request is seen; completion forwarded combinationally.
// Backpressure: requesters hold until their rsp; a silent memory is aborted by the watchdog.
module core_bus_arbiter #(
    parameter int TIMEOUT_CYCLES = 1024,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  instr_req_i,
    input  logic                  instr_flush_i,
    input  logic [ADDR_WIDTH-1:0] instr_addr_i,
    output logic                  instr_rsp_o,
    output logic [31:0]           instr_data_o,
    input  logic                  data_rd_i,
    input  logic                  data_wr_i,
    input  logic [ADDR_WIDTH-1:0] data_addr_i,
    input  logic [31:0]           data_write_i,
    output logic                  data_rsp_o,
    output logic [31:0]           data_read_o,
    output logic                  mem_rd_o,
    output logic                  mem_wr_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_write_o,
    input  logic                  mem_rsp_i,
    input  logic [31:0]           mem_read_i,
    output logic                  bus_error_o
);
    typedef enum logic [1:0] {IDLE, INSTR_BUSY, DATA_BUSY, INSTR_DROP} state_t;

    localparam int CW = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CW-1:0] LIMIT   = (TIMEOUT_CYCLES > 0) ? CW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CW-1:0] CNT_MAX = '1;

    state_t                  state, state_nxt;
    logic [CW-1:0]           cnt, cnt_nxt;
    logic                    rd_nxt, wr_nxt;
    logic [ADDR_WIDTH-1:0]   addr_nxt;
    logic [31:0]             wdat_nxt;
    logic                    busy, expired, done, data_req, instr_ok, pick_data;

`ifdef ARBITER_ROUND_ROBIN_EN
    typedef enum logic {LAST_INSTR, LAST_DATA} grant_t;
    grant_t last, last_nxt;
`endif

    assign busy     = (state != IDLE);
    assign expired  = (TIMEOUT_CYCLES > 0) && busy && (cnt == LIMIT) && !mem_rsp_i;
    assign done     = busy && (mem_rsp_i || expired);
    assign data_req = data_rd_i | data_wr_i;
    // a flush in the request cycle cancels the fetch before it is ever granted
    assign instr_ok = instr_req_i & ~instr_flush_i;

`ifdef ARBITER_ROUND_ROBIN_EN
    assign pick_data = data_req && (!instr_ok || last == LAST_INSTR);
`else
    assign pick_data = data_req;
`endif

    always_comb begin
        state_nxt    = state;
        cnt_nxt      = cnt;
        rd_nxt       = mem_rd_o;
        wr_nxt       = mem_wr_o;
        addr_nxt     = mem_addr_o;
        wdat_nxt     = mem_write_o;
        instr_rsp_o  = 1'b0;
        instr_data_o = 32'h0;
        data_rsp_o   = 1'b0;
        data_read_o  = 32'h0;
        bus_error_o  = expired;
`ifdef ARBITER_ROUND_ROBIN_EN
        last_nxt     = last;
`endif
        case (state)
            IDLE: begin
                if (pick_data) begin
                    state_nxt = DATA_BUSY;
                    rd_nxt    = data_rd_i;
                    wr_nxt    = data_wr_i;
                    addr_nxt  = data_addr_i;
                    wdat_nxt  = data_write_i;
                    cnt_nxt   = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
                    last_nxt  = LAST_DATA;
`endif
                end else if (instr_ok) begin
                    state_nxt = INSTR_BUSY;
                    rd_nxt    = 1'b1;
                    wr_nxt    = 1'b0;
                    addr_nxt  = instr_addr_i;
                    wdat_nxt  = 32'h0;
                    cnt_nxt   = '0;
`ifdef ARBITER_ROUND_ROBIN_EN
                    last_nxt  = LAST_INSTR;
`endif
                end
            end
            INSTR_BUSY: begin
                if (done) begin
                    instr_rsp_o = !instr_flush_i;
                    if (!instr_flush_i && !expired) instr_data_o = mem_read_i;
                end else if (instr_flush_i) begin
                    state_nxt = INSTR_DROP;
                end
            end
            DATA_BUSY: begin
                if (done) begin
                    data_rsp_o = 1'b1;
                    if (!expired) data_read_o = mem_read_i;
                end
            end
            default: ;
        endcase
        // the dropped fetch still runs to completion on the memory side
        if (done) begin
            state_nxt = IDLE;
            rd_nxt    = 1'b0;
            wr_nxt    = 1'b0;
        end else if (busy && cnt != CNT_MAX) begin
            cnt_nxt = cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            cnt         <= '0;
            mem_rd_o    <= 1'b0;
            mem_wr_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_write_o <= 32'h0;
`ifdef ARBITER_ROUND_ROBIN_EN
            last        <= LAST_INSTR;
`endif
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            mem_rd_o    <= rd_nxt;
            mem_wr_o    <= wr_nxt;
            mem_addr_o  <= addr_nxt;
            mem_write_o <= wdat_nxt;
`ifdef ARBITER_ROUND_ROBIN_EN
            last        <= last_nxt;
`endif
        end
    end
endmodule

// File: tb/tb_core_bus_arbiter.sv
// Bench for core_bus_arbiter: directed vector table, arbitration-order sequence,
// then randomized traffic checked against a transaction-level model.
module tb_core_bus_arbiter;
    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        instr_req_i, instr_flush_i, instr_rsp_o;
    logic [31:0] instr_addr_i, instr_data_o;
    logic        data_rd_i, data_wr_i, data_rsp_o;
    logic [31:0] data_addr_i, data_write_i, data_read_o;
    logic        mem_rd_o, mem_wr_o, mem_rsp_i, bus_error_o;
    logic [31:0] mem_addr_o, mem_write_o, mem_read_i;

    always #5 clk = ~clk;

    core_bus_arbiter #(.TIMEOUT_CYCLES(TO), .ADDR_WIDTH(32)) dut (
        .clk(clk), .rst_n(rst_n),
        .instr_req_i(instr_req_i), .instr_flush_i(instr_flush_i), .instr_addr_i(instr_addr_i),
        .instr_rsp_o(instr_rsp_o), .instr_data_o(instr_data_o),
        .data_rd_i(data_rd_i), .data_wr_i(data_wr_i), .data_addr_i(data_addr_i),
        .data_write_i(data_write_i), .data_rsp_o(data_rsp_o), .data_read_o(data_read_o),
        .mem_rd_o(mem_rd_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_write_o(mem_write_o), .mem_rsp_i(mem_rsp_i), .mem_read_i(mem_read_i),
        .bus_error_o(bus_error_o)
    );

    logic [132:0] obs;
    assign obs = {mem_rd_o, mem_wr_o, mem_addr_o, mem_write_o, instr_rsp_o, instr_data_o,
                  data_rsp_o, data_read_o, bus_error_o};

    int checks = 0;
    int passed = 0;

    task automatic check(input string name, input logic [132:0] got, input logic [132:0] exp);
        checks++;
        if (got === exp) passed++;
        else $display("FAIL %s: got %h expected %h", name, got, exp);
    endtask

    typedef struct {
        logic        rst, ireq, fl, drd, dwr, mr;
        logic [31:0] ia, da, dw, md;
        logic [132:0] exp;
    } vec_t;

    function automatic vec_t v(input int rst, input int ireq, input int fl, input logic [31:0] ia,
                               input int drd, input int dwr, input logic [31:0] da, input logic [31:0] dw,
                               input int mr, input logic [31:0] md,
                               input int erd, input int ewr, input logic [31:0] ea, input logic [31:0] ew,
                               input int eir, input logic [31:0] eid, input int edr, input logic [31:0] edd,
                               input int eer);
        vec_t r;
        r.rst = (rst != 0); r.ireq = (ireq != 0); r.fl = (fl != 0); r.ia = ia;
        r.drd = (drd != 0); r.dwr = (dwr != 0); r.da = da; r.dw = dw;
        r.mr = (mr != 0); r.md = md;
        r.exp = {erd != 0, ewr != 0, ea, ew, eir != 0, eid, edr != 0, edd, eer != 0};
        return r;
    endfunction

    task automatic apply(input vec_t t);
        rst_n = t.rst; instr_req_i = t.ireq; instr_flush_i = t.fl; instr_addr_i = t.ia;
        data_rd_i = t.drd; data_wr_i = t.dwr; data_addr_i = t.da; data_write_i = t.dw;
        mem_rsp_i = t.mr; mem_read_i = t.md;
    endtask

    task automatic clear_inputs();
        instr_req_i = 0; instr_flush_i = 0; instr_addr_i = 0;
        data_rd_i = 0; data_wr_i = 0; data_addr_i = 0; data_write_i = 0;
        mem_rsp_i = 0; mem_read_i = 0;
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 0; clear_inputs();
        @(posedge clk); #1;
        rst_n = 1;
    endtask

    // reference model: one in-flight transaction record, timed by absolute cycle numbers
    int          cyc, gcyc, who, last;
    bit          pend, kill, m_rd, m_wr;
    logic [31:0] m_addr, m_wdat;

    task automatic model_reset();
        pend = 0; kill = 0; who = 0; last = 1; m_rd = 0; m_wr = 0;
        m_addr = 0; m_wdat = 0; cyc = 0; gcyc = 0;
    endtask

    vec_t vq[$];
    logic [31:0] g [3];
    logic [31:0] eg [3];

    initial begin
        #300000;
        $display("FAIL global_time_limit: got no finish required finish");
        $fatal(1);
    end

    initial begin
        rst_n = 0; clear_inputs();
        repeat (2) @(posedge clk);

        // reset, collision, fetch-only, flush, flush-in-idle, idle rsp, timeout, reset mid-transaction
        vq.push_back(v(0, 0,0,0,       0,0,0,0,               0,0,        0,0,0,0,                 0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h300,   0,1,'h2000,'hDEADBEEF, 0,0,        0,0,0,0,                 0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h300,   0,1,'h2000,'hDEADBEEF, 0,0,        0,1,'h2000,'hDEADBEEF,   0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h300,   0,1,'h2000,'hDEADBEEF, 1,'h55,     0,1,'h2000,'hDEADBEEF,   0,0,1,'h55,0));
        vq.push_back(v(1, 1,0,'h300,   0,0,0,0,               0,0,        0,0,'h2000,'hDEADBEEF,   0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h300,   0,0,0,0,               0,0,        1,0,'h300,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h300,   0,0,0,0,               1,'h1234,   1,0,'h300,0,             1,'h1234,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,'h300,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h100,   0,0,0,0,               0,0,        0,0,'h300,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h100,   0,0,0,0,               0,0,        1,0,'h100,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h100,   0,0,0,0,               0,0,        1,0,'h100,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h100,   0,0,0,0,               1,'h13,     1,0,'h100,0,             1,'h13,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,'h100,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h400,   0,0,0,0,               0,0,        0,0,'h100,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,1,'h400,   0,0,0,0,               0,0,        1,0,'h400,0,             0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               1,'hAA,     1,0,'h400,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h200,   0,0,0,0,               0,0,        0,0,'h400,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h200,   0,0,0,0,               0,0,        1,0,'h200,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h200,   0,0,0,0,               1,'h77,     1,0,'h200,0,             1,'h77,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,'h200,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,1,'h500,   0,0,0,0,               0,0,        0,0,'h200,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,0,'h500,   0,0,0,0,               0,0,        0,0,'h200,0,             0,0,0,0,0));
        vq.push_back(v(1, 1,1,'h500,   0,0,0,0,               1,'h99,     1,0,'h500,0,             0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,'h500,0,             0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               1,'hFF,     0,0,'h500,0,             0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       1,0,'h3000,0,          0,0,        0,0,'h500,0,             0,0,0,0,0));
        for (int k = 0; k < TO - 1; k++)
            vq.push_back(v(1, 0,0,0,   1,0,'h3000,0,          0,0,        1,0,'h3000,0,            0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       1,0,'h3000,0,          0,'hCAFE,   1,0,'h3000,0,            0,0,1,0,1));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,'h3000,0,            0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       1,0,'h3100,0,          0,0,        0,0,'h3000,0,            0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       1,0,'h3100,0,          0,0,        1,0,'h3100,0,            0,0,0,0,0));
        vq.push_back(v(0, 0,0,0,       1,0,'h3100,0,          0,0,        1,0,'h3100,0,            0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               1,'h42,     0,0,0,0,                 0,0,0,0,0));
        vq.push_back(v(1, 0,0,0,       0,0,0,0,               0,0,        0,0,0,0,                 0,0,0,0,0));

        for (int k = 0; k < vq.size(); k++) begin
            @(posedge clk); #1;
            apply(vq[k]);
            #1;
            check($sformatf("vec%0d", k), obs, vq[k].exp);
        end

        // both requesters hold continuously; record the order of three grants
        do_reset();
        instr_req_i = 1; instr_addr_i = 'h600; data_rd_i = 1; data_addr_i = 'h700;
        begin
            int  ng;
            bit  prev_rd;
            ng = 0; prev_rd = 0;
            for (int k = 0; k < 3; k++) g[k] = 0;
`ifdef ARBITER_ROUND_ROBIN_EN
            eg[0] = 'h700; eg[1] = 'h600; eg[2] = 'h700;
`else
            eg[0] = 'h700; eg[1] = 'h700; eg[2] = 'h700;
`endif
            for (int c = 0; c < 40 && ng < 3; c++) begin
                @(posedge clk); #1;
                if (mem_rd_o && !prev_rd) begin
                    g[ng] = mem_addr_o;
                    ng++;
                end
                prev_rd    = mem_rd_o;
                mem_rsp_i  = mem_rd_o;
                mem_read_i = 32'h1;
            end
            check("arb_grant_count", 133'(ng), 133'(3));
            for (int k = 0; k < 3; k++)
                check($sformatf("arb_grant%0d", k), 133'(g[k]), 133'(eg[k]));
        end

        // randomized traffic against the reference model
        do_reset();
        model_reset();
        begin
            bit          seen_irsp, seen_drsp, flush_prev, expired, finish, irsp, drsp, dreq, iok, pick_d;
            logic [31:0] idat, ddat;
            int          kind, age;
            seen_irsp = 0; seen_drsp = 0;
            for (int c = 0; c < 600; c++) begin
                @(posedge clk); #1;
                flush_prev = instr_flush_i;
                if (!instr_req_i || seen_irsp || flush_prev) begin
                    instr_req_i  = ($urandom_range(0, 2) == 0);
                    instr_addr_i = $urandom & 32'h0000FFFC;
                end
                instr_flush_i = !flush_prev && ($urandom_range(0, 9) == 0);
                if (!(data_rd_i || data_wr_i) || seen_drsp) begin
                    kind         = $urandom_range(0, 3);
                    data_rd_i    = (kind == 1);
                    data_wr_i    = (kind == 2);
                    data_addr_i  = $urandom;
                    data_write_i = $urandom;
                end
                mem_rsp_i  = ($urandom_range(0, 3) == 0);
                mem_read_i = $urandom;
                #1;

                age     = cyc - gcyc + 1;
                expired = pend && (age == TO) && !mem_rsp_i;
                finish  = pend && (mem_rsp_i || expired);
                irsp    = finish && who == 1 && !kill && !instr_flush_i;
                drsp    = finish && who == 2;
                idat    = (irsp && !expired) ? mem_read_i : 32'h0;
                ddat    = (drsp && !expired) ? mem_read_i : 32'h0;
                check($sformatf("rand%0d", c), obs,
                      {pend && m_rd, pend && m_wr, m_addr, m_wdat, irsp, idat, drsp, ddat, expired});
                seen_irsp = instr_rsp_o;
                seen_drsp = data_rsp_o;

                if (pend) begin
                    if (finish) pend = 0;
                    else if (who == 1 && instr_flush_i) kill = 1;
                end else begin
                    dreq = data_rd_i || data_wr_i;
                    iok  = instr_req_i && !instr_flush_i;
`ifdef ARBITER_ROUND_ROBIN_EN
                    pick_d = dreq && (!iok || last == 1);
`else
                    pick_d = dreq;
`endif
                    if (pick_d) begin
                        pend = 1; kill = 0; who = 2; gcyc = cyc + 1; last = 2;
                        m_rd = data_rd_i; m_wr = data_wr_i; m_addr = data_addr_i; m_wdat = data_write_i;
                    end else if (iok) begin
                        pend = 1; kill = 0; who = 1; gcyc = cyc + 1; last = 1;
                        m_rd = 1; m_wr = 0; m_addr = instr_addr_i; m_wdat = 0;
                    end
                end
                cyc++;
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
